// File: rtl/disp_spi_write_sched.sv
// Write scheduler for the seven-segment display SPI link: replays the enable/radix
// configuration after reset, then round-robins register writes from two requesters.
module disp_spi_write_sched #(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter logic [7:0]  INIT_ENABLE = 8'hFF,
  parameter logic [7:0]  INIT_RADIX  = 8'h00
) (
  input  logic       spi_sclk_i,
  input  logic       rst_low_i,
  input  logic       req0_i,
  input  logic [3:0] addr0_i,
  input  logic [7:0] data0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic [3:0] addr1_i,
  input  logic [7:0] data1_i,
  output logic       ack1_o,
  output logic       spi_ss_o,
  output logic       spi_mosi_o,
  output logic       busy_o,
  output logic       init_done_o
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StInitEn, StInitRx, StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            ss_q, ss_d;
  logic            mosi_q, mosi_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            busy_q, busy_d;
  logic            init_done_q, init_done_d;
  logic            init_phase_q, init_phase_d;
  logic            last_grant_q, last_grant_d;

  logic            load;
  logic [15:0]     frame;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    init_done_d  = init_done_q;
    init_phase_d = init_phase_q;
    last_grant_d = last_grant_q;
    load         = 1'b0;
    frame        = 16'h0000;

    unique case (state_q)
      StInitEn: begin
        load  = 1'b1;
        frame = {4'b0001, 4'd0, INIT_ENABLE};
      end
      StInitRx: begin
        load  = 1'b1;
        frame = {4'b0001, 4'd9, INIT_RADIX};
      end
      StIdle: begin
        // Requester 0 wins a tie only when requester 1 was the previous grantee.
        if (req0_i && (!req1_i || last_grant_q)) begin
          load         = 1'b1;
          frame        = {4'b0001, addr0_i, data0_i};
          ack0_d       = 1'b1;
          last_grant_d = 1'b0;
        end else if (req1_i) begin
          load         = 1'b1;
          frame        = {4'b0001, addr1_i, data1_i};
          ack1_d       = 1'b1;
          last_grant_d = 1'b1;
        end
      end
      StShift: begin
        mosi_d    = shreg_q[15];
        shreg_d   = {shreg_q[14:0], 1'b1};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          ss_d      = 1'b1;
          mosi_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GapLast) begin
          if (!init_done_q && !init_phase_q) begin
            init_phase_d = 1'b1;
            state_d      = StInitRx;
          end else begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StInitEn;
    endcase

    // First frame bit goes out in the cycle right after the loading edge.
    if (load) begin
      ss_d      = 1'b0;
      mosi_d    = frame[15];
      shreg_d   = {frame[14:0], 1'b1};
      bit_cnt_d = 4'd0;
      state_d   = StShift;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      state_q      <= StInitEn;
      shreg_q      <= 16'hFFFF;
      bit_cnt_q    <= 4'd0;
      gap_cnt_q    <= '0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b1;
      init_done_q  <= 1'b0;
      init_phase_q <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      init_done_q  <= init_done_d;
      init_phase_q <= init_phase_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign spi_ss_o    = ss_q;
  assign spi_mosi_o  = mosi_q;
  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;

endmodule
